// File: rtl/shell_a.sv
// rtl/shell_a.sv - tank shell ballistics: launch, flight, ground impact and edge miss
// Optional macro SHELL_EXPLODE_EN adds a timed EXPLODE state after ground impact.
module shell_a #(
  parameter int SHELL_X_STEP   = 4,
  parameter int GRAVITY        = 1,
  parameter int VY_MAX         = 15,
  parameter int LAUNCH_OFFSET  = 8,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       shoot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic [9:0] ShellS,
  output logic       shell_active,
  output logic       shell_visible,
  output logic       hit_ground,
  output logic       miss,
  output logic       explode
);

  typedef enum logic [1:0] {IDLE, FLIGHT, EXPLODE} state_t;

  state_t             state;
  logic [9:0]         x;
  logic signed [10:0] y;
  logic signed [10:0] vx;
  logic signed [10:0] vy;
  logic               shoot_q;

`ifdef SHELL_EXPLODE_EN
  localparam int CNT_W = $clog2(EXPLODE_FRAMES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  logic               launch;
  logic signed [10:0] next_x;
  logic signed [10:0] next_y;
  logic signed [10:0] vy_inc;
  logic signed [10:0] vy_next;
  logic [31:0]        gx;
  logic [31:0]        g_sq;
  logic [31:0]        g_lin;
  logic [31:0]        ground32;
  logic signed [10:0] ground_y;
  logic               off_edge;
  logic               on_ground;

  assign launch  = shoot & ~shoot_q;
  assign next_x  = $signed({1'b0, x}) + vx;
  assign next_y  = y + vy;
  assign vy_inc  = vy + 11'(GRAVITY);
  assign vy_next = (vy_inc > $signed(11'(VY_MAX))) ? $signed(11'(VY_MAX)) : vy_inc;

  // Terrain profile; each term truncates on its own, so evaluation order matters.
  assign gx       = {22'd0, next_x[9:0]};
  assign g_sq     = (32'd607 * gx * gx) / 32'd1562500;
  assign g_lin    = (32'd71 * gx) / 32'd500;
  assign ground32 = g_sq - g_lin + 32'd267;
  assign ground_y = $signed(ground32[10:0]);

  // Edge test has priority over the ground test so a miss never also reports a hit.
  assign off_edge  = next_x[10] | (next_x > $signed(11'(X_MAX)));
  assign on_ground = ~next_y[10] & ({22'd0, next_y[9:0]} >= ground32);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      x          <= 10'd0;
      y          <= 11'sd0;
      vx         <= 11'sd0;
      vy         <= 11'sd0;
      shoot_q    <= 1'b0;
      hit_ground <= 1'b0;
      miss       <= 1'b0;
`ifdef SHELL_EXPLODE_EN
      cnt        <= '0;
`endif
    end else begin
      shoot_q    <= shoot;
      hit_ground <= 1'b0;
      miss       <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            x     <= TankX;
            y     <= $signed({1'b0, TankY}) - 11'(LAUNCH_OFFSET);
            vx    <= (Direction == 2'd0) ? -11'(SHELL_X_STEP) : 11'(SHELL_X_STEP);
            vy    <= {y_component[9], y_component};
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          vy <= vy_next;
          if (off_edge) begin
            miss  <= 1'b1;
            state <= IDLE;
          end else if (on_ground) begin
            x          <= next_x[9:0];
            y          <= ground_y;
            hit_ground <= 1'b1;
`ifdef SHELL_EXPLODE_EN
            cnt        <= '0;
            state      <= EXPLODE;
`else
            state      <= IDLE;
`endif
          end else begin
            x <= next_x[9:0];
            y <= next_y;
          end
        end
`ifdef SHELL_EXPLODE_EN
        EXPLODE: begin
          if (cnt == CNT_W'(EXPLODE_FRAMES - 1)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign ShellX        = x;
  assign ShellY        = y[10] ? 10'd0 : y[9:0];
  assign ShellS        = 10'd2;
  assign shell_active  = (state != IDLE);
  assign shell_visible = (state == FLIGHT) && !y[10] && (y <= $signed(11'(Y_MAX)));

`ifdef SHELL_EXPLODE_EN
  assign explode = (state == EXPLODE);
`else
  assign explode = 1'b0;
`endif

endmodule

// File: tb/tb_shell_a.sv
// tb/tb_shell_a.sv - directed bench for shell_a launch, flight, miss, impact and reset
module tb_shell_a;

  logic       frame_clk;
  logic       Reset_n;
  logic       shoot;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic [1:0] Direction;
  logic [9:0] y_component;
  logic [9:0] ShellX;
  logic [9:0] ShellY;
  logic [9:0] ShellS;
  logic       shell_active;
  logic       shell_visible;
  logic       hit_ground;
  logic       miss;
  logic       explode;

  int total = 0;
  int bad   = 0;

  shell_a dut (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .shoot        (shoot),
    .TankX        (TankX),
    .TankY        (TankY),
    .Direction    (Direction),
    .y_component  (y_component),
    .ShellX       (ShellX),
    .ShellY       (ShellY),
    .ShellS       (ShellS),
    .shell_active (shell_active),
    .shell_visible(shell_visible),
    .hit_ground   (hit_ground),
    .miss         (miss),
    .explode      (explode)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset;
    shoot = 1'b0;
    @(negedge frame_clk);
    Reset_n = 1'b0;
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    shoot = 1'b0; TankX = 10'd0; TankY = 10'd0; Direction = 2'd0; y_component = 10'd0;
    #1;
    total++;
    if ({ShellX, ShellY, ShellS, shell_active, shell_visible, hit_ground, miss, explode} !== {10'd0, 10'd0, 10'd2, 5'b0}) begin
      $display("FAIL reset_outputs got=%h want=%h",
        {ShellX, ShellY, ShellS, shell_active, shell_visible, hit_ground, miss, explode}, {10'd0, 10'd0, 10'd2, 5'b0});
      bad++;
    end
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_launch_flight;
    do_reset();
    TankX = 10'd140; TankY = 10'd210; Direction = 2'd1; y_component = 10'h3F6; shoot = 1'b1;
    step();
    total++;
    if ({ShellX, ShellY, shell_active, shell_visible} !== {10'd140, 10'd202, 2'b11}) begin
      $display("FAIL launch_pos got=%0d,%0d,%b%b want=140,202,11", ShellX, ShellY, shell_active, shell_visible);
      bad++;
    end
    step();
    total++;
    if ({ShellX, ShellY, shell_visible} !== {10'd144, 10'd192, 1'b1}) begin
      $display("FAIL flight1 got=%0d,%0d,%b want=144,192,1", ShellX, ShellY, shell_visible);
      bad++;
    end
    step();
    total++;
    if ({ShellX, ShellY} !== {10'd148, 10'd183}) begin
      $display("FAIL flight2_vy got=%0d,%0d want=148,183", ShellX, ShellY);
      bad++;
    end
  endtask

  task automatic test_miss_relaunch;
    do_reset();
    TankX = 10'd630; TankY = 10'd210; Direction = 2'd1; y_component = 10'h3F0; shoot = 1'b1;
    step();
    total++;
    if ({ShellX, ShellY} !== {10'd630, 10'd202}) begin
      $display("FAIL miss_launch got=%0d,%0d want=630,202", ShellX, ShellY);
      bad++;
    end
    shoot = 1'b0;
    step();
    total++;
    if ({ShellX, ShellY} !== {10'd634, 10'd186}) begin
      $display("FAIL miss_f1 got=%0d,%0d want=634,186", ShellX, ShellY);
      bad++;
    end
    shoot = 1'b1; TankX = 10'd100;
    step();
    total++;
    if ({ShellX, ShellY, miss, shell_active} !== {10'd638, 10'd171, 1'b0, 1'b1}) begin
      $display("FAIL no_relaunch got=%0d,%0d,%b%b want=638,171,01", ShellX, ShellY, miss, shell_active);
      bad++;
    end
    step();
    total++;
    if ({miss, hit_ground, shell_active, ShellX, ShellY} !== {3'b100, 10'd638, 10'd171}) begin
      $display("FAIL miss_pulse got=%b%b%b,%0d,%0d want=100,638,171", miss, hit_ground, shell_active, ShellX, ShellY);
      bad++;
    end
    step();
    total++;
    if ({miss, shell_active} !== 2'b00) begin
      $display("FAIL miss_one_frame got=%b%b want=00", miss, shell_active);
      bad++;
    end
    shoot = 1'b0;
    step();
    shoot = 1'b1;
    step();
    total++;
    if ({ShellX, ShellY, shell_active} !== {10'd100, 10'd202, 1'b1}) begin
      $display("FAIL relaunch got=%0d,%0d,%b want=100,202,1", ShellX, ShellY, shell_active);
      bad++;
    end
  endtask

  task automatic test_hit;
    int n;
    do_reset();
    TankX = 10'd100; TankY = 10'd258; Direction = 2'd1; y_component = 10'd0; shoot = 1'b1;
    step();
    shoot = 1'b0;
    repeat (3) step();
    total++;
    if ({ShellX, ShellY, hit_ground} !== {10'd112, 10'd253, 1'b0}) begin
      $display("FAIL pre_hit got=%0d,%0d,%b want=112,253,0", ShellX, ShellY, hit_ground);
      bad++;
    end
    step();
    total++;
    if ({hit_ground, miss, ShellX, ShellY} !== {2'b10, 10'd116, 10'd256}) begin
      $display("FAIL hit_pulse got=%b%b,%0d,%0d want=10,116,256", hit_ground, miss, ShellX, ShellY);
      bad++;
    end
`ifdef SHELL_EXPLODE_EN
    total++;
    if ({explode, shell_active, shell_visible} !== 3'b110) begin
      $display("FAIL explode_start got=%b%b%b want=110", explode, shell_active, shell_visible);
      bad++;
    end
    n = 1;
    shoot = 1'b1;
    step();
    if (explode) n++;
    total++;
    if ({hit_ground, ShellX, ShellY} !== {1'b0, 10'd116, 10'd256}) begin
      $display("FAIL explode_hold got=%b,%0d,%0d want=0,116,256", hit_ground, ShellX, ShellY);
      bad++;
    end
    for (int i = 0; i < 40 && explode; i++) begin
      shoot = i[0];
      step();
      if (explode) n++;
    end
    shoot = 1'b0;
    total++;
    if (n !== 16 || shell_active !== 1'b0 || ShellX !== 10'd116) begin
      $display("FAIL explode_len got=%0d,%b,%0d want=16,0,116", n, shell_active, ShellX);
      bad++;
    end
`else
    n = 0;
    total++;
    if ({explode, shell_active} !== 2'b00) begin
      $display("FAIL hit_idle got=%b%b want=00 n=%0d", explode, shell_active, n);
      bad++;
    end
    step();
    total++;
    if ({hit_ground, shell_active} !== 2'b00) begin
      $display("FAIL hit_one_frame got=%b%b want=00", hit_ground, shell_active);
      bad++;
    end
`endif
  endtask

  task automatic test_clamp;
    do_reset();
    TankX = 10'd100; TankY = 10'd300; Direction = 2'd1; y_component = 10'd0; shoot = 1'b1;
    step();
    total++;
    if (ShellY !== 10'd292) begin
      $display("FAIL clamp_launch got=%0d want=292", ShellY);
      bad++;
    end
    shoot = 1'b0;
    step();
    total++;
    if ({hit_ground, ShellX, ShellY} !== {1'b1, 10'd104, 10'd257}) begin
      $display("FAIL clamp_ground got=%b,%0d,%0d want=1,104,257", hit_ground, ShellX, ShellY);
      bad++;
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    TankX = 10'd140; TankY = 10'd210; Direction = 2'd1; y_component = 10'h3F6; shoot = 1'b1;
    step();
    step();
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if ({ShellX, ShellY, ShellS, shell_active, shell_visible, hit_ground, miss, explode} !== {10'd0, 10'd0, 10'd2, 5'b0}) begin
      $display("FAIL async_reset got=%h want=%h",
        {ShellX, ShellY, ShellS, shell_active, shell_visible, hit_ground, miss, explode}, {10'd0, 10'd0, 10'd2, 5'b0});
      bad++;
    end
    step();
    step();
    total++;
    if ({shell_active, hit_ground, miss, ShellX} !== {3'b000, 10'd0}) begin
      $display("FAIL reset_held got=%b%b%b,%0d want=000,0", shell_active, hit_ground, miss, ShellX);
      bad++;
    end
    #2 Reset_n = 1'b1;
    step();
    total++;
    if ({shell_active, ShellX, ShellY} !== {1'b1, 10'd140, 10'd202}) begin
      $display("FAIL post_reset_launch got=%b,%0d,%0d want=1,140,202", shell_active, ShellX, ShellY);
      bad++;
    end
  endtask

  task automatic test_high_arc;
    do_reset();
    TankX = 10'd300; TankY = 10'd210; Direction = 2'd0; y_component = 10'h200; shoot = 1'b1;
    step();
    shoot = 1'b0;
    step();
    total++;
    if ({ShellX, ShellY, shell_visible, shell_active} !== {10'd296, 10'd0, 2'b01}) begin
      $display("FAIL above_top1 got=%0d,%0d,%b%b want=296,0,01", ShellX, ShellY, shell_visible, shell_active);
      bad++;
    end
    step();
    total++;
    if ({ShellX, ShellY, shell_active, hit_ground, miss} !== {10'd292, 10'd0, 3'b100}) begin
      $display("FAIL above_top2 got=%0d,%0d,%b%b%b want=292,0,100", ShellX, ShellY, shell_active, hit_ground, miss);
      bad++;
    end
  endtask

  task automatic test_saturation;
    do_reset();
    TankX = 10'd140; TankY = 10'd210; Direction = 2'd1; y_component = 10'h3EC; shoot = 1'b1;
    step();
    shoot = 1'b0;
    repeat (20) step();
    total++;
    if ({ShellX, ShellY, shell_visible, shell_active} !== {10'd220, 10'd0, 2'b01}) begin
      $display("FAIL apex_negative got=%0d,%0d,%b%b want=220,0,01", ShellX, ShellY, shell_visible, shell_active);
      bad++;
    end
    repeat (15) step();
    total++;
    if ({ShellX, ShellY} !== {10'd280, 10'd97}) begin
      $display("FAIL descent got=%0d,%0d want=280,97", ShellX, ShellY);
      bad++;
    end
    step();
    step();
    total++;
    if ({ShellX, ShellY} !== {10'd288, 10'd127}) begin
      $display("FAIL vy_saturate got=%0d,%0d want=288,127", ShellX, ShellY);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_launch_flight();
    test_miss_relaunch();
    test_hit();
    test_clamp();
    test_reset_midflight();
    test_high_arc();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shell_a.md
SHELL_A -- requirements
Module: shell_a

Interface
REQ-001 SHALL have parameters: SHELL_X_STEP=4 (horizontal px/frame); GRAVITY=1 (vy increment/frame); VY_MAX=15 (vy saturation); LAUNCH_OFFSET=8 (px above tank); X_MAX=639; Y_MAX=479; EXPLODE_FRAMES=16.
REQ-002 SHALL have ports: frame_clk in 1 (sole clock, all state on rising edge); Reset_n in 1 (asynchronous, active-low).
REQ-003 SHALL have inputs: shoot in 1 (fire request level); TankX in 10; TankY in 10 (launch point); Direction in 2 (0=left, 1=right, others=right); y_component in 10 (two's-complement initial vy, negative=up).
REQ-004 SHALL have outputs: ShellX out 10; ShellY out 10; ShellS out 10 (constant 2); shell_active out 1; shell_visible out 1; hit_ground out 1 (1-frame pulse); miss out 1 (1-frame pulse); explode out 1.

Function
REQ-005 SHALL implement FSM IDLE, FLIGHT, EXPLODE; one transition per frame_clk edge maximum.
REQ-006 SHALL register shoot into shoot_q every frame; launch event = shoot & ~shoot_q.
REQ-007 SHALL accept a launch only in IDLE; launch events in FLIGHT/EXPLODE are discarded, not queued.
REQ-008 On launch: X<=TankX, Y<=TankY-LAUNCH_OFFSET (11-bit signed), vx<=-SHELL_X_STEP if Direction==0 else +SHELL_X_STEP, vy<=sign-extended y_component, state<=FLIGHT.
REQ-009 Each FLIGHT frame: nextX=X+vx, nextY=Y+vy (11-bit signed); then vy<=min(vy+GRAVITY, VY_MAX).
REQ-010 SHALL compute ground(x)=(607*x*x)/1562500-(71*x)/500+267, each term truncated, 32-bit unsigned intermediates, combinational on nextX.
REQ-011 If nextX<0 or nextX>X_MAX: state<=IDLE, miss=1 for one frame, X/Y not updated; checked before ground test.
REQ-012 Else if nextY>=0 and nextY>=ground(nextX): X<=nextX, Y<=ground(nextX), hit_ground=1 for one frame, state<=EXPLODE.
REQ-013 Else X<=nextX, Y<=nextY; nextY<0 (above top) SHALL continue flight.
REQ-014 shell_active=1 in FLIGHT and EXPLODE; shell_visible=1 only in FLIGHT with 0<=Y<=Y_MAX.
REQ-015 ShellY SHALL output Y[9:0] when Y>=0, else 0; ShellX=X.
REQ-016 EXPLODE SHALL hold X/Y, assert explode, count EXPLODE_FRAMES frames, then IDLE; launches ignored throughout.
REQ-017 hit_ground and miss SHALL never assert in the same frame.

Reset
REQ-018 Reset_n low SHALL immediately force: state=IDLE, X=0, Y=0, vx=0, vy=0, shoot_q=0, counter=0, all 1-bit outputs 0, ShellX=ShellY=0; ShellS stays 2.
REQ-019 Reset mid-FLIGHT/EXPLODE SHALL abort with no hit_ground/miss pulse; shoot held high across deassertion SHALL not launch until it falls and rises again... except that shoot_q=0 after reset, so shoot high on first post-reset edge SHALL launch (defined behaviour).

Configuration
REQ-020 Macro SHELL_EXPLODE_EN: defined -> EXPLODE state and counter as REQ-016; undefined -> hit transitions directly to IDLE, explode tied 0, no counter logic; hit_ground pulse unchanged.

Verification
REQ-021 TankX=140, TankY=210, Direction=1, y_component=10'h3F6, shoot 0->1 -> launch frame X=140,Y=202; next frame X=144,Y=192,vy=-9; shell_visible=1.
REQ-022 TankX=630, Direction=1, y_component=10'h3F0 -> X 634, 638, then miss pulse on third FLIGHT frame, IDLE, no hit_ground.
REQ-023 Second shoot edge mid-flight -> trajectory unchanged, no relaunch; after return to IDLE, new edge launches.
REQ-024 Flat shot lands -> hit_ground one frame, Y=ground(X); with SHELL_EXPLODE_EN explode high exactly 16 frames then IDLE; without, IDLE next frame.
REQ-025 Reset_n low during FLIGHT -> all outputs 0 asynchronously, no pulses; shoot held high at release -> launch on first edge.
REQ-026 y_component=10'h200 (very negative) -> Y<0 frames keep flying, ShellY=0, shell_visible=0, vy saturates at 15 on descent.
